// File: rtl/femtosoc_bus_arbiter.sv
// rtl/femtosoc_bus_arbiter.sv - two-master round-robin bus arbiter with slave wait timeout
//
// Ports:
//   clk, reset            sole clock (rising edge); asynchronous active-high reset
//   mX_valid/addr/wdata/wstrb  master X request (wstrb == 0 means read), X = 0, 1
//   mX_ready/rdata/err    master X completion, read data, timeout pulse
//   s_valid/addr/wdata/wstrb   request forwarded to the slave for the granted master
//   s_ready/rdata         slave completion and read data
//   timeout_flag          sticky timeout indicator, cleared only by reset
//   grant                 one-hot owner (01 = master 0, 10 = master 1), 00 when idle
module femtosoc_bus_arbiter #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,

    output logic        timeout_flag,
    output logic [1:0]  grant
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          last_m1;     // last owner was master 1, so master 0 wins the next tie

    logic busy0;
    logic busy1;
    logic cur_valid;
    logic timeout_now;

    // Completion path is purely combinational so the slave's ready reaches
    // the master in the same cycle.
    always_comb begin
        busy0       = (state == BUSY0);
        busy1       = (state == BUSY1);
        cur_valid   = (busy0 & m0_valid) | (busy1 & m1_valid);
        // A slave ready arriving in the timeout cycle wins: it is a normal completion.
        timeout_now = (TIMEOUT != 0) && cur_valid && !s_ready && (wait_cnt == TO_CNT);

        s_valid = cur_valid & ~timeout_now;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (busy0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (busy1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end

        m0_ready = busy0 & m0_valid & (s_ready | timeout_now);
        m1_ready = busy1 & m1_valid & (s_ready | timeout_now);
        m0_err   = busy0 & timeout_now;
        m1_err   = busy1 & timeout_now;
        m0_rdata = '0;
        m1_rdata = '0;
        if (busy0) begin
            m0_rdata = timeout_now ? ERR_RDATA : s_rdata;
        end
        if (busy1) begin
            m1_rdata = timeout_now ? ERR_RDATA : s_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            last_m1      <= 1'b1;
            timeout_flag <= 1'b0;
            grant        <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (m0_valid && (!m1_valid || last_m1)) begin
                        state   <= BUSY0;
                        grant   <= 2'b01;
                        last_m1 <= 1'b0;
                    end else if (m1_valid) begin
                        state   <= BUSY1;
                        grant   <= 2'b10;
                        last_m1 <= 1'b1;
                    end
                end
                BUSY0, BUSY1: begin
                    // A dropped valid (protocol violation), a completion or a
                    // timeout all end the grant through GAP.
                    if (!cur_valid || s_ready || timeout_now) begin
                        state <= GAP;
                        grant <= 2'b00;
                        if (timeout_now) begin
                            timeout_flag <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_femtosoc_bus_arbiter.sv
// tb/tb_femtosoc_bus_arbiter.sv - scoreboard bench for femtosoc_bus_arbiter
module tb_femtosoc_bus_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        m0_valid, m0_ready, m0_err, m1_valid, m1_ready, m1_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready, timeout_flag;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;

    femtosoc_bus_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .timeout_flag(timeout_flag), .grant(grant)
    );

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int gap; } req_t;
    typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;

    req_t rq0[$];
    req_t rq1[$];
    exp_t eq0[$];
    exp_t eq1[$];
    bit   busy_d0, busy_d1;
    int   vectors = 0;
    int   miscompares = 0;

    // Slave behaviour: ready comes 'lat' cycles after the grant starts.
    function automatic int slave_lat(input logic [31:0] a);
        return (a == 32'h10) ? 2 : int'(a[6:4]);
    endfunction

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'hA5A5_0F0F);
    endfunction

    // Reference: slave ready on busy cycle lat+1; the arbiter gives up after
    // TO+1 busy cycles unless ready arrives in that very cycle.
    function automatic exp_t model(input logic [31:0] a);
        exp_t e;
        int   lat;
        lat = slave_lat(a);
        if (lat > TO) begin
            e.rdata = ERR; e.err = 1'b1; e.cyc = TO + 1;
        end else begin
            e.rdata = slave_data(a); e.err = 1'b0; e.cyc = lat + 1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_m(input int x, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (x == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end
    endtask

    task automatic push(input int x, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int gap);
        req_t r;
        r.addr = a; r.wdata = d; r.wstrb = s; r.gap = gap;
        if (x == 0) rq0.push_back(r);
        else        rq1.push_back(r);
    endtask

    task automatic drive(input int x);
        req_t r;
        exp_t e;
        bit   done;
        bit   rdy;
        forever begin
            @(posedge clk); #1;
            set_m(x, 1'b0, $urandom, $urandom, 4'($urandom));
            if (reset) continue;
            if (x == 0) begin
                if (rq0.size() == 0) continue;
                r = rq0.pop_front(); busy_d0 = 1'b1;
            end else begin
                if (rq1.size() == 0) continue;
                r = rq1.pop_front(); busy_d1 = 1'b1;
            end
            if (r.gap > 0) begin
                repeat (r.gap) @(posedge clk);
                #1;
            end
            e = model(r.addr);
            if (x == 0) eq0.push_back(e);
            else        eq1.push_back(e);
            set_m(x, 1'b1, r.addr, r.wdata, r.wstrb);
            done = 1'b0;
            for (int n = 0; n < 40 && !done; n++) begin
                @(negedge clk);
                rdy = (x == 0) ? m0_ready : m1_ready;
                if (reset) begin
                    // Transfer abandoned by reset: it must never complete.
                    set_m(x, 1'b0, 32'h0, 32'h0, 4'h0);
                    if (x == 0) void'(eq0.pop_back());
                    else        void'(eq1.pop_back());
                    done = 1'b1;
                end else if (rdy) begin
                    done = 1'b1;
                end
            end
            if (!done) check("xfer_complete_bound", 64'd0, 64'd1);
            if (x == 0) busy_d0 = 1'b0;
            else        busy_d1 = 1'b0;
        end
    endtask

    initial drive(0);
    initial drive(1);

    initial begin : slave
        int cnt;
        cnt = 0; s_ready = 1'b0; s_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (grant != 2'b00) begin
                s_ready = (cnt == slave_lat(s_addr));
                s_rdata = s_ready ? slave_data(s_addr) : $urandom;
                cnt++;
            end else begin
                cnt = 0;
                s_ready = 1'($urandom_range(0, 1));
                s_rdata = $urandom;
            end
        end
    end

    initial begin : monitor
        logic [1:0] prev_grant;
        logic [1:0] eg;
        int         busy_n;
        logic       mflag, mlast, v0p, v1p;
        exp_t       e;
        prev_grant = 2'b00; busy_n = 0; mflag = 1'b0; mlast = 1'b1; v0p = 1'b0; v1p = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("reset_outputs", {grant, s_valid, m0_ready, m1_ready, m0_err, m1_err, timeout_flag}, 64'd0);
                mflag = 1'b0; mlast = 1'b1; prev_grant = 2'b00; busy_n = 0; v0p = 1'b0; v1p = 1'b0;
                continue;
            end
            check("timeout_flag", timeout_flag, mflag);
            check("ready_exclusive", m0_ready & m1_ready, 64'd0);
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                eg = (v0p && v1p) ? (mlast ? 2'b01 : 2'b10) : (v0p ? 2'b01 : 2'b10);
                check("grant_order", grant, eg);
                mlast = eg[1];
            end
            busy_n = (grant != 2'b00) ? busy_n + 1 : 0;
            if (grant == 2'b01 || grant == 2'b10) begin
                if (grant == 2'b01) begin
                    check("route0", {s_addr, s_wdata}, {m0_addr, m0_wdata});
                    check("route0_wstrb", s_wstrb, m0_wstrb);
                    check("m1_quiet", {m1_ready, m1_err, m1_rdata}, 64'd0);
                end else begin
                    check("route1", {s_addr, s_wdata}, {m1_addr, m1_wdata});
                    check("route1_wstrb", s_wstrb, m1_wstrb);
                    check("m0_quiet", {m0_ready, m0_err, m0_rdata}, 64'd0);
                end
                if ((grant == 2'b01 && m0_ready) || (grant == 2'b10 && m1_ready)) begin
                    if ((grant == 2'b01 ? eq0.size() : eq1.size()) == 0) begin
                        check("unexpected_ready", 64'd1, 64'd0);
                    end else begin
                        e = (grant == 2'b01) ? eq0.pop_front() : eq1.pop_front();
                        check("rdata", (grant == 2'b01) ? m0_rdata : m1_rdata, e.rdata);
                        check("err", (grant == 2'b01) ? m0_err : m1_err, e.err);
                        check("latency", busy_n, e.cyc);
                        check("s_valid_done", s_valid, !e.err);
                        if (e.err) mflag = 1'b1;
                    end
                end else begin
                    check("s_valid_wait", s_valid, (grant == 2'b01) ? m0_valid : m1_valid);
                    check("err_idle", m0_err | m1_err, 64'd0);
                end
            end else begin
                check("grant_onehot", grant, 2'b00);
                check("bus_idle", {s_valid, s_wstrb, s_addr}, 64'd0);
                check("s_wdata_idle", s_wdata, 64'd0);
                check("masters_idle", {m0_ready, m1_ready, m0_err, m1_err}, 64'd0);
            end
            v0p = m0_valid; v1p = m1_valid; prev_grant = grant;
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (rq0.size() == 0 && rq1.size() == 0 && eq0.size() == 0 && eq1.size() == 0
                && !busy_d0 && !busy_d1) break;
        end
        if (n >= budget) check("drain_bound", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        int n;
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        busy_d0 = 1'b0; busy_d1 = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;

        // Read, slave answers on the third busy cycle.
        push(0, 32'h10, 32'h0, 4'h0, 0);
        wait_idle(100);
        // Partial-strobe write routing.
        push(0, 32'h0000_0200, 32'hAABB_CCDD, 4'b0011, 1);
        wait_idle(100);
        // Slave ready coincides with the timeout cycle.
        push(1, 32'h0000_0040, 32'h0, 4'h0, 0);
        wait_idle(100);
        check("flag_after_coincide", timeout_flag, 64'd0);
        // Slave never answers in time.
        push(1, 32'h0000_0070, 32'h0, 4'h0, 0);
        wait_idle(100);
        check("flag_after_timeout", timeout_flag, 64'd1);

        // Both masters requesting back to back.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            push(0, $urandom & ~32'h70, $urandom, 4'h0, 0);
            push(1, $urandom & ~32'h70, $urandom, 4'hF, 0);
        end
        wait_idle(400);

        // Reset pulse between edges while master 1 owns the bus.
        push(1, 32'h0000_0070, 32'h0, 4'h0, 0);
        for (n = 0; n < 30 && grant != 2'b10; n++) @(negedge clk);
        check("reach_busy1", grant, 2'b10);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("reset_drop", {s_valid, grant, m1_ready}, 64'd0);
        #3 reset = 1'b0;
        wait_idle(100);
        @(negedge clk);
        push(0, 32'h0000_0300, 32'h0, 4'h0, 0);
        push(1, 32'h0000_0400, 32'h0, 4'h0, 0);
        for (n = 0; n < 30 && grant == 2'b00; n++) @(negedge clk);
        check("first_after_reset", grant, 2'b01);
        wait_idle(200);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            push(0, $urandom, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom_range(0, 3));
            push(1, $urandom, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom_range(0, 3));
        end
        wait_idle(4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/femtosoc_bus_arbiter.md
FEMTOSOC_BUS_ARBITER -- requirements
Module: femtosoc_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles a grant may wait for s_ready; 0 disables the timeout.
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on a timeout.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named as follows.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL provide ports (each mX_* exists for X = 0 and 1):
- mX_valid  in  1  master X request.
- mX_ready  out  1  master X transfer complete.
- mX_addr  in  32  master X address.
- mX_wdata  in  32  master X write data.
- mX_wstrb  in  4  master X byte strobes; 0 means read.
- mX_rdata  out  32  master X read data.
- mX_err  out  1  one-cycle pulse with mX_ready when the transfer timed out.
- s_valid  out  1  slave request.
- s_ready  in  1  slave done.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_wstrb  out  4  slave byte strobes.
- s_rdata  in  32  slave read data.
- timeout_flag  out  1  sticky; set on any timeout; cleared only by reset.
- grant  out  2  one-hot current owner; 2'b00 when idle.

Function
REQ-005 SHALL implement an FSM with states IDLE, BUSY0, BUSY1 and GAP.
REQ-006 In IDLE, with only mX_valid high, SHALL move to BUSYX at the next edge.
REQ-007 In IDLE, with both requests high, SHALL grant the master not granted last (round-robin); the first arbitration after reset SHALL favour master 0.
REQ-008 In BUSYX, s_valid SHALL equal mX_valid.
REQ-009 In BUSYX, s_addr, s_wdata and s_wstrb SHALL be combinationally muxed from master X.
REQ-010 In IDLE and GAP, s_valid SHALL be 0, and s_addr, s_wdata and s_wstrb SHALL be 0.
REQ-011 In BUSYX, mX_ready SHALL equal s_ready and mX_rdata SHALL equal s_rdata in the same cycle (zero added latency on completion).
REQ-012 The non-granted master's ready and err SHALL be 0, and its rdata SHALL be 0.
REQ-013 On a completion in BUSYX (s_ready high), the FSM SHALL go to GAP; GAP SHALL last exactly one cycle and then go to IDLE.
- GAP lets the master drop valid before it can be re-arbitrated.
- Minimum request-to-request spacing per grant is therefore 3 cycles.
REQ-014 A wait counter (width ceil(log2(TIMEOUT+1)), minimum 1 bit) SHALL clear on entry to BUSYX and increment each BUSYX cycle in which s_ready is 0.
REQ-015 When TIMEOUT != 0 and the counter equals TIMEOUT with s_ready still 0, the arbiter SHALL, in that same cycle:
- assert mX_ready=1, mX_err=1 and mX_rdata=ERR_RDATA;
- force s_valid to 0;
- set timeout_flag;
- go to GAP.
REQ-016 If s_ready and the timeout condition coincide, the arbiter SHALL treat it as a normal completion: err 0, rdata = s_rdata, timeout_flag unchanged.
REQ-017 If the granted master drops valid while in BUSYX (protocol violation), the arbiter SHALL drop s_valid in the same cycle, assert no ready, and go to GAP.
REQ-018 s_ready while in IDLE or GAP SHALL be ignored.
REQ-019 grant SHALL be registered and decoded from state: 2'b01 in BUSY0, 2'b10 in BUSY1, 2'b00 otherwise.
REQ-020 At most one of m0_ready and m1_ready SHALL be high in any cycle.

Reset
REQ-021 While reset is high, independent of clk, the arbiter SHALL force:
- state IDLE, counter 0, last-grant pointer to "master 1" (so master 0 wins first);
- timeout_flag 0 and grant 2'b00;
- all ready and err outputs 0, s_valid 0.
REQ-022 Reset asserted mid-transfer SHALL abandon the transfer with no ready pulse; after reset deasserts, arbitration SHALL restart from IDLE at the first clk edge.

Verification
REQ-023 Bench SHALL run: m0 read to 0x10, s_ready 2 cycles after s_valid, s_rdata=0x1234_5678 -> m0_ready for 1 cycle, m0_rdata=0x1234_5678, grant 01 then 00.
REQ-024 Bench SHALL run: m0 and m1 requesting continuously from reset -> grant sequence 01,00,00,10,00,00,01,..., strictly alternating.
REQ-025 Bench SHALL run: TIMEOUT=4, s_ready held 0 -> on the 5th BUSY cycle m1_ready=1, m1_err=1, m1_rdata=0xDEAD_BEEF, timeout_flag=1 and stays 1.
REQ-026 Bench SHALL run: TIMEOUT=4, s_ready rises in the timeout cycle -> normal completion, err 0, timeout_flag 0.
REQ-027 Bench SHALL run: write with m0_wstrb=4'b0011, data 0xAABB_CCDD -> s_wstrb=4'b0011, s_wdata=0xAABB_CCDD while grant=01.
REQ-028 Bench SHALL run: reset pulsed between clk edges during BUSY1 -> s_valid, grant and m1_ready drop immediately with no ready pulse; the next arbitration grants m0 first.
